debug_mem_reader: RTL and testbench
===================================

DEBUG_MEM_READER -- requirements
Module: debug_mem_reader

Interface
REQ-001 Parameter CANT_BITS_ADDR, default 12: byte address width of the data memory debug port; the 2 LSBs select the byte.
REQ-002 Parameter CANT_BITS_REGISTROS, default 32: data word width.
REQ-003 Parameter RAM_DEPTH, default 1024: number of words swept.
REQ-004 Port i_clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port i_soft_reset, input, 1: reset, synchronous and active-high.
REQ-006 Port i_start, input, 1: one-cycle pulse that starts a dump.
REQ-007 Port o_control_address_mem, output, 1: high selects the debug address into the memory stage.
REQ-008 Port o_control_write_read_mem, output, 1: write/read select toward the memory stage; this block only reads, so it is constant 0.
REQ-009 Port o_enable_mem_datos, output, 1: memory enable during the sweep.
REQ-010 Port o_address_debug_unit, output, CANT_BITS_ADDR: byte address {word_idx, 2'b00}.
REQ-011 Port i_dato_mem_to_debug_unit, input, CANT_BITS_REGISTROS: read data from the memory stage.
REQ-012 Port i_bit_sucio_to_debug_unit, input, 1: dirty bit of the addressed word.
REQ-013 Port o_tx_data, output, 8: byte toward the UART transmitter.
REQ-014 Port o_tx_valid, output, 1 / i_tx_ready, input, 1: byte handshake.
REQ-015 Port o_busy, output, 1: high from IDLE exit until DONE.
REQ-016 Port o_done, output, 1: one-cycle completion pulse.

Function
REQ-017 FSM states: IDLE, SET_ADDR, WAIT_MEM, CAPTURE, SEND, NEXT, END_MARK, DONE.
REQ-018 Transitions:
- IDLE to SET_ADDR on i_start, with word_idx = 0.
- i_start is ignored in every state other than IDLE.
REQ-019 Read timing: the address is driven in SET_ADDR, data is valid one cycle later (WAIT_MEM), and data plus dirty bit are registered in CAPTURE.
REQ-020 CAPTURE selects the next state:
- word emitted: go to SEND with a 6-byte frame.
- word skipped: go to NEXT.
REQ-021 Frame byte order:
- word_idx as 16 bits, zero-extended, MSB first;
- then the data word as 4 bytes, MSB first.
REQ-022 Handshake:
- a byte transfers on a cycle where o_tx_valid && i_tx_ready;
- o_tx_data is held stable while o_tx_valid && !i_tx_ready;
- o_tx_valid never drops without a transfer.
REQ-023 NEXT increments word_idx; wrap-around:
- word_idx == RAM_DEPTH-1 goes to END_MARK;
- otherwise NEXT goes to SET_ADDR.
REQ-024 END_MARK sends bytes 0xFF, 0xFF, then goes to DONE.
REQ-025 DONE asserts o_done for one cycle, then returns to IDLE.
REQ-026 Clean-word cost: 4 cycles (SET_ADDR, WAIT_MEM, CAPTURE, NEXT).
REQ-027 o_control_address_mem and o_enable_mem_datos are high in every state except IDLE and DONE.
REQ-028 o_address_debug_unit is held constant from SET_ADDR through NEXT of the same word.

Reset
REQ-029 Reset values when i_soft_reset = 1 at a clock edge:
- state IDLE;
- word_idx 0;
- o_tx_valid 0, o_tx_data 0;
- o_busy 0, o_done 0;
- o_control_address_mem 0, o_enable_mem_datos 0;
- o_address_debug_unit 0.
REQ-030 Reset mid-frame aborts the dump: no further bytes and no o_done pulse.

Configuration
REQ-031 Macro DEBUG_MEM_SKIP_CLEAN_EN.
- Defined: CAPTURE emits a frame only when the dirty bit = 1.
- Undefined: every word is emitted regardless of the dirty bit, and the dirty-bit input is unused.

Structure
REQ-032 Shared package debug_unit_pkg holds:
- the FSM state encoding;
- END_MARK_BYTE = 8'hFF;
- FRAME_BYTES = 6.
REQ-033 One sub-module, frame_serializer:
- loads a 48-bit frame;
- shifts it out MSB-first under the valid/ready handshake;
- reports last-byte-accepted.

Verification
REQ-034 Skip-clean build, all words clean, i_tx_ready = 1, i_start pulse:
- bytes out are exactly FF FF;
- o_done occurs after 4*1024 + end-marker cycles;
- o_busy is high throughout.
REQ-035 Skip-clean build, word 2 dirty holding 0xFFDECBAA:
- bytes out are 00 02 FF DE CB AA FF FF;
- o_address_debug_unit = 12'h008 while word 2 is read.
REQ-036 Backpressure, same memory as REQ-035, i_tx_ready low for 5 cycles on the 3rd byte:
- o_tx_data is held at 0xFF;
- o_tx_valid stays high;
- the byte sequence is unchanged.
REQ-037 i_soft_reset pulsed while the 4th frame byte is pending:
- next cycle o_tx_valid = 0, o_busy = 0, state IDLE;
- no o_done pulse;
- a new i_start restarts from word 0.
REQ-038 Build without DEBUG_MEM_SKIP_CLEAN_EN, memory all zero:
- 1024 frames, the last being 03 FF 00 00 00 00;
- followed by FF FF;
- a second i_start during the dump has no effect.

Source files
------------

// File: rtl/debug_unit_pkg.sv
// debug_unit_pkg: shared types and constants for the debug memory dump path.
package debug_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SET_ADDR,
        ST_WAIT_MEM,
        ST_CAPTURE,
        ST_SEND,
        ST_NEXT,
        ST_END_MARK,
        ST_DONE
    } state_t;

    localparam logic [7:0]  END_MARK_BYTE = 8'hFF;
    localparam int unsigned FRAME_BYTES   = 6;
    localparam int unsigned FRAME_W       = 8 * FRAME_BYTES;
    localparam int unsigned BYTE_CNT_W    = 3;

    // One dump frame: word index then data word, both MSB first on the wire.
    typedef struct packed {
        logic [15:0] idx;
        logic [31:0] data;
    } frame_t;

endpackage

// File: rtl/frame_serializer.sv
// frame_serializer: loads a 48-bit frame and shifts it out MSB-first as bytes
// under a valid/ready handshake; flags the cycle the last byte is accepted.
module frame_serializer
    import debug_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  frame_t                frame,
    input  logic [BYTE_CNT_W-1:0] nbytes,
    input  logic                  tx_ready,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    output logic                  last_c
);

    logic [FRAME_W-1:0]    shreg;
    logic [BYTE_CNT_W-1:0] remaining;

    assign tx_data = shreg[FRAME_W-1 -: 8];
    assign last_c  = tx_valid && tx_ready && (remaining == BYTE_CNT_W'(1));

    // Shift register and byte counter; data only moves on an accepted byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg     <= '0;
            remaining <= '0;
            tx_valid  <= 1'b0;
        end else if (load) begin
            shreg     <= frame;
            remaining <= nbytes;
            tx_valid  <= (nbytes != '0);
        end else if (tx_valid && tx_ready) begin
            shreg     <= {shreg[FRAME_W-9:0], 8'h00};
            remaining <= remaining - BYTE_CNT_W'(1);
            tx_valid  <= (remaining != BYTE_CNT_W'(1));
        end
    end

endmodule

// File: rtl/debug_mem_reader.sv
// debug_mem_reader: sweeps the data memory through its debug port and streams
// each word as a 6-byte frame (index, data) followed by an FF FF end marker.
// Optional build macro DEBUG_MEM_SKIP_CLEAN_EN: only dirty words are emitted.
module debug_mem_reader
    import debug_unit_pkg::*;
#(
    parameter int unsigned CANT_BITS_ADDR      = 12,
    parameter int unsigned CANT_BITS_REGISTROS = 32,
    parameter int unsigned RAM_DEPTH           = 1024
)
(
    input  logic                           i_clock,
    input  logic                           i_soft_reset,
    input  logic                           i_start,
    output logic                           o_control_address_mem,
    output logic                           o_control_write_read_mem,
    output logic                           o_enable_mem_datos,
    output logic [CANT_BITS_ADDR-1:0]      o_address_debug_unit,
    input  logic [CANT_BITS_REGISTROS-1:0] i_dato_mem_to_debug_unit,
    input  logic                           i_bit_sucio_to_debug_unit,
    output logic [7:0]                     o_tx_data,
    output logic                           o_tx_valid,
    input  logic                           i_tx_ready,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int unsigned IDX_W = CANT_BITS_ADDR - 2;

    state_t                state, state_next;
    logic [IDX_W-1:0]      word_idx, word_idx_next;
    logic                  ser_load_c;
    frame_t                ser_frame_c;
    logic [BYTE_CNT_W-1:0] ser_nbytes_c;
    logic                  last_c;
    logic                  emit_c;

`ifdef DEBUG_MEM_SKIP_CLEAN_EN
    assign emit_c = i_bit_sucio_to_debug_unit;
`else
    logic unused_dirty;
    assign unused_dirty = i_bit_sucio_to_debug_unit;
    assign emit_c       = 1'b1;
`endif

    // The dump path never writes memory.
    assign o_control_write_read_mem = 1'b0;

    // Next-state, word index and serializer load decode.
    always_comb begin
        state_next    = state;
        word_idx_next = word_idx;
        ser_load_c    = 1'b0;
        ser_frame_c   = '0;
        ser_nbytes_c  = '0;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    state_next    = ST_SET_ADDR;
                    word_idx_next = '0;
                end
            end
            ST_SET_ADDR: state_next = ST_WAIT_MEM;
            ST_WAIT_MEM: state_next = ST_CAPTURE;
            ST_CAPTURE: begin
                if (emit_c) begin
                    state_next       = ST_SEND;
                    ser_load_c       = 1'b1;
                    ser_frame_c.idx  = 16'(word_idx);
                    ser_frame_c.data = 32'(i_dato_mem_to_debug_unit);
                    ser_nbytes_c     = BYTE_CNT_W'(FRAME_BYTES);
                end else begin
                    state_next = ST_NEXT;
                end
            end
            ST_SEND: begin
                if (last_c) state_next = ST_NEXT;
            end
            ST_NEXT: begin
                if (word_idx == IDX_W'(RAM_DEPTH - 1)) begin
                    state_next      = ST_END_MARK;
                    word_idx_next   = '0;
                    ser_load_c      = 1'b1;
                    ser_frame_c.idx = {END_MARK_BYTE, END_MARK_BYTE};
                    ser_nbytes_c    = BYTE_CNT_W'(2);
                end else begin
                    state_next    = ST_SET_ADDR;
                    word_idx_next = word_idx + IDX_W'(1);
                end
            end
            ST_END_MARK: begin
                if (last_c) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State and word index registers.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            state    <= ST_IDLE;
            word_idx <= '0;
        end else begin
            state    <= state_next;
            word_idx <= word_idx_next;
        end
    end

    // Registered outputs decoded from the upcoming state so they align with it.
    always_ff @(posedge i_clock) begin
        if (i_soft_reset) begin
            o_address_debug_unit  <= '0;
            o_busy                <= 1'b0;
            o_done                <= 1'b0;
            o_control_address_mem <= 1'b0;
            o_enable_mem_datos    <= 1'b0;
        end else begin
            if (state_next == ST_SET_ADDR) begin
                o_address_debug_unit <= {word_idx_next, 2'b00};
            end
            o_busy                <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            o_done                <= (state_next == ST_DONE);
            o_control_address_mem <= (state_next != ST_IDLE) && (state_next != ST_DONE);
            o_enable_mem_datos    <= (state_next != ST_IDLE) && (state_next != ST_DONE);
        end
    end

    frame_serializer u_serializer (
        .clk      (i_clock),
        .rst      (i_soft_reset),
        .load     (ser_load_c),
        .frame    (ser_frame_c),
        .nbytes   (ser_nbytes_c),
        .tx_ready (i_tx_ready),
        .tx_data  (o_tx_data),
        .tx_valid (o_tx_valid),
        .last_c   (last_c)
    );

endmodule

// File: tb/tb_debug_mem_reader.sv
// tb_debug_mem_reader: directed bench for debug_mem_reader; adapts its expected
// values to whether DEBUG_MEM_SKIP_CLEAN_EN is defined.
module tb_debug_mem_reader;

    localparam int AW     = 12;
    localparam int DW     = 32;
    localparam int DEPTH  = 1024;
    localparam int BUDGET = 20000;

`ifdef DEBUG_MEM_SKIP_CLEAN_EN
    localparam int CYC_CLEAN   = 4 * 1024 + 2;
    localparam int CYC_W2      = 4 * 1024 + 2 + 6;
    localparam int SIZE_CLEAN  = 2;
    localparam int SIZE_W2     = 8;
    localparam int W2_BASE     = 0;
`else
    localparam int CYC_CLEAN   = 10 * 1024 + 2;
    localparam int CYC_W2      = 10 * 1024 + 2;
    localparam int SIZE_CLEAN  = 6 * 1024 + 2;
    localparam int SIZE_W2     = 6 * 1024 + 2;
    localparam int W2_BASE     = 12;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          ctrl_addr;
    logic          wr_rd;
    logic          mem_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] rdata;
    logic          rdirty;
    logic [7:0]    tx_data;
    logic          valid;
    logic          ready;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem   [DEPTH];
    logic          dirty [DEPTH];

    logic [7:0]    got_q[$];
    logic [AW-1:0] addr_q[$];
    logic [7:0]    exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt, busy_low, ctl_err, hold_err, stall_cycles, stall_ff;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always #5 clk = ~clk;

    debug_mem_reader dut (
        .i_clock                   (clk),
        .i_soft_reset              (rst),
        .i_start                   (start),
        .o_control_address_mem     (ctrl_addr),
        .o_control_write_read_mem  (wr_rd),
        .o_enable_mem_datos        (mem_en),
        .o_address_debug_unit      (addr),
        .i_dato_mem_to_debug_unit  (rdata),
        .i_bit_sucio_to_debug_unit (rdirty),
        .o_tx_data                 (tx_data),
        .o_tx_valid                (valid),
        .i_tx_ready                (ready),
        .o_busy                    (busy),
        .o_done                    (done)
    );

    // Synchronous-read memory model: data one cycle after the address.
    always @(posedge clk) begin
        rdata  <= mem[addr[AW-1:2]];
        rdirty <= dirty[addr[AW-1:2]];
    end

    // Byte monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && ready) begin
                got_q.push_back(tx_data);
                addr_q.push_back(addr);
            end
            if (valid && !ready) begin
                stall_cycles++;
                if (tx_data == 8'hFF) stall_ff++;
            end
            if (prev_stall && (!valid || tx_data != prev_data)) hold_err++;
            if (done) done_cnt++;
            prev_stall = valid && !ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference stream built from the bench's own memory image.
    task automatic build_exp();
        logic [47:0] f;
        exp_q.delete();
        exp_addr_q.delete();
        for (int w = 0; w < DEPTH; w++) begin
`ifdef DEBUG_MEM_SKIP_CLEAN_EN
            if (!dirty[w]) continue;
`endif
            f = {16'(w), mem[w]};
            for (int b = 0; b < 6; b++) begin
                exp_q.push_back(f[47 - 8 * b -: 8]);
                exp_addr_q.push_back(AW'(w * 4));
            end
        end
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'hFF);
    endtask

    task automatic check_stream(input string tag);
        int n;
        int e = 0;
        build_exp();
        check({tag, "_size"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (got_q[i] != exp_q[i]) e++;
            if (i < exp_q.size() - 2 && addr_q[i] != exp_addr_q[i]) e++;
        end
        check({tag, "_bytes"}, 32'(e), 0);
    endtask

    task automatic run_dump(input int stall_at, input int restart_at, output int cycles);
        int stall_left = 0;
        bit stalled    = 1'b0;
        got_q.delete();
        addr_q.delete();
        done_cnt = 0; busy_low = 0; ctl_err = 0; hold_err = 0;
        stall_cycles = 0; stall_ff = 0;
        @(posedge clk); #1; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        cycles = 0;
        while (cycles < BUDGET) begin
            @(negedge clk);
            if (done) break;
            if (!busy) busy_low++;
            if (!ctrl_addr || !mem_en || wr_rd) ctl_err++;
            @(posedge clk); #1;
            cycles++;
            start = (cycles == restart_at);
            if (!stalled && stall_at >= 0 && got_q.size() == stall_at) begin
                stalled    = 1'b1;
                stall_left = 5;
            end
            ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
        end
        check("dump_terminates", 32'(cycles < BUDGET), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic reset_mid_frame();
        int n = 0;
        got_q.delete();
        addr_q.delete();
        done_cnt = 0;
        @(posedge clk); #1; start = 1'b1; ready = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        while (got_q.size() < 3 && n < BUDGET) begin
            @(posedge clk); #1;
            n++;
        end
        ready = 1'b0;
        check("rst_pre_bytes", 32'(got_q.size()), 3);
        @(posedge clk); #1;
        check("rst_pre_valid", 32'(valid), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", 32'(valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ctrl_addr", 32'(ctrl_addr), 0);
        check("rst_done", 32'(done), 0);
        ready = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_cnt), 0);
        check("rst_no_more_bytes", 32'(got_q.size()), 3);
    endtask

    initial begin
        int cyc;
        logic [7:0] w2_bytes [6];
        w2_bytes = '{8'h00, 8'h02, 8'hFF, 8'hDE, 8'hCB, 8'hAA};
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]   = '0;
            dirty[i] = 1'b0;
        end
        rst = 1'b1; start = 1'b0; ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_valid", 32'(valid), 0);
        check("reset_data", 32'(tx_data), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_ctrl_addr", 32'(ctrl_addr), 0);
        check("reset_mem_en", 32'(mem_en), 0);
        check("reset_addr", 32'(addr), 0);
        check("reset_wr_rd", 32'(wr_rd), 0);
        @(posedge clk); #1; rst = 1'b0;

        // All-clean / all-zero memory with a stray start mid-dump.
        run_dump(-1, 500, cyc);
        check("clean_cycles", 32'(cyc), 32'(CYC_CLEAN));
        check("clean_size", 32'(got_q.size()), 32'(SIZE_CLEAN));
        check("clean_end0", 32'(got_q[SIZE_CLEAN - 2]), 'hFF);
        check("clean_end1", 32'(got_q[SIZE_CLEAN - 1]), 'hFF);
        check("clean_busy", 32'(busy_low), 0);
        check("clean_ctl", 32'(ctl_err), 0);
        check("clean_done_pulses", 32'(done_cnt), 1);
        check_stream("clean_stream");
`ifndef DEBUG_MEM_SKIP_CLEAN_EN
        check("last_frame_b0", 32'(got_q[SIZE_CLEAN - 8]), 'h03);
        check("last_frame_b1", 32'(got_q[SIZE_CLEAN - 7]), 'hFF);
        check("last_frame_b2", 32'(got_q[SIZE_CLEAN - 6]), 'h00);
        check("last_frame_b5", 32'(got_q[SIZE_CLEAN - 3]), 'h00);
`endif

        // Word 2 dirty with data, 5-cycle stall on the byte 0xFF.
        mem[2]   = 32'hFFDECBAA;
        dirty[2] = 1'b1;
        run_dump(W2_BASE + 2, -1, cyc);
        check("w2_cycles", 32'(cyc), 32'(CYC_W2 + 5));
        check("w2_size", 32'(got_q.size()), 32'(SIZE_W2));
        for (int i = 0; i < 6; i++) begin
            check($sformatf("w2_byte%0d", i), 32'(got_q[W2_BASE + i]), 32'(w2_bytes[i]));
        end
        check("w2_addr", 32'(addr_q[W2_BASE]), 'h008);
        check("stall_cycles", 32'(stall_cycles), 5);
        check("stall_data_ff", 32'(stall_ff), 5);
        check("stall_hold", 32'(hold_err), 0);
        check("w2_done_pulses", 32'(done_cnt), 1);
        check_stream("w2_stream");

        // Abort mid-frame, then restart from word 0.
        reset_mid_frame();
        run_dump(-1, -1, cyc);
        check("restart_cycles", 32'(cyc), 32'(CYC_W2));
        check("restart_done_pulses", 32'(done_cnt), 1);
        check_stream("restart_stream");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
